ram_test_seq: RTL and testbench

Memory test sequencer that sits directly upstream of the AXI-Stream RAM and also consumes its read-back stream. On a start pulse it sweeps an address range, sends one write command per address (data = address XOR seed) and checks each returned byte. It reports error count, first failing address and timeout status. Exactly one command is outstanding at a time.

---
 rtl/ram_test_seq.sv | 145 ++++++++++++++
 tb/tb_ram_test_seq.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_test_seq.sv
// Memory test sequencer: sweeps an address range, writes (addr ^ seed) to the
// AXI-Stream RAM one command at a time and checks each read-back byte.
module ram_test_seq #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        start,
  input  logic [7:0]  base_addr,
  input  logic [8:0]  count,
  input  logic [7:0]  seed,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic        busy,
  output logic        done,
  output logic [8:0]  err_count,
  output logic [7:0]  first_err_addr,
  output logic        first_err_valid,
  output logic        timeout
);

  localparam int unsigned WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP, DONE} state_t;

  state_t        state;
  logic [7:0]    base_r;
  logic [7:0]    seed_r;
  logic [8:0]    cnt_r;
  logic [8:0]    idx;
  logic [WW-1:0] wait_cnt;

  logic [7:0] cur_addr;
  logic [7:0] next_addr;
  logic [7:0] exp_data;
  logic       rsp_ok;
  logic       last;
  logic       tmo_hit;

  always_comb begin
    cur_addr  = base_r + idx[7:0];
    next_addr = cur_addr + 8'd1;
    exp_data  = cur_addr ^ seed_r;
    rsp_ok    = (s_axis_tdata[31:8] == '0) && (s_axis_tdata[7:0] == exp_data);
    last      = (idx == cnt_r - 9'd1);
    // Fires on the cycle whose edge would bring the counter to TIMEOUT
    tmo_hit   = (TIMEOUT != 0) && ((32'(wait_cnt) + 32'd1) == TIMEOUT);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state           <= IDLE;
      base_r          <= '0;
      seed_r          <= '0;
      cnt_r           <= '0;
      idx             <= '0;
      wait_cnt        <= '0;
      m_axis_tdata    <= '0;
      m_axis_tvalid   <= 1'b0;
      s_axis_tready   <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      err_count       <= '0;
      first_err_addr  <= '0;
      first_err_valid <= 1'b0;
      timeout         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            base_r          <= base_addr;
            cnt_r           <= count;
            seed_r          <= seed;
            idx             <= '0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            timeout         <= 1'b0;
            busy            <= 1'b1;
            if (count == 9'd0) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              m_axis_tvalid <= 1'b1;
              m_axis_tdata  <= {16'b0, base_addr ^ seed, base_addr};
              state         <= SEND;
            end
          end
        end

        SEND: begin
          if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            s_axis_tready <= 1'b1;
            wait_cnt      <= '0;
            state         <= WAIT_RSP;
          end
        end

        WAIT_RSP: begin
          // A response on the timeout cycle still counts as a response
          if (s_axis_tvalid) begin
            s_axis_tready <= 1'b0;
            if (!rsp_ok) begin
              err_count <= err_count + 9'd1;
              if (!first_err_valid) begin
                first_err_addr  <= cur_addr;
                first_err_valid <= 1'b1;
              end
            end
            if (last) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              idx           <= idx + 9'd1;
              m_axis_tvalid <= 1'b1;
              m_axis_tdata  <= {16'b0, next_addr ^ seed_r, next_addr};
              state         <= SEND;
            end
          end else if (tmo_hit) begin
            s_axis_tready <= 1'b0;
            err_count     <= err_count + 9'd1;
            timeout       <= 1'b1;
            done          <= 1'b1;
            state         <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_test_seq.sv
// Directed bench for ram_test_seq: a cooperative RAM model answers commands
// with the echoed byte (optionally corrupted) while each task checks results.
module tb_ram_test_seq;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic [8:0]  count = '0;
  logic [7:0]  seed = '0;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic [31:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        busy;
  logic        done;
  logic [8:0]  err_count;
  logic [7:0]  first_err_addr;
  logic        first_err_valid;
  logic        timeout;

  int errors = 0;
  int checks = 0;

  logic [31:0] cmds [0:299];
  int ncmd, ndone, nbusy, done_at;

  always #5 aclk = ~aclk;

  ram_test_seq #(.TIMEOUT(64)) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .start           (start),
    .base_addr       (base_addr),
    .count           (count),
    .seed            (seed),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tready   (m_axis_tready),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tready   (s_axis_tready),
    .busy            (busy),
    .done            (done),
    .err_count       (err_count),
    .first_err_addr  (first_err_addr),
    .first_err_valid (first_err_valid),
    .timeout         (timeout)
  );

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Runs one sweep with ready partners; records commands, done pulses and busy cycles.
  // bad_lo / bad_hi pick the response index to corrupt; restart_at pulses start mid-sweep.
  task automatic run_sweep(input logic [7:0] b, input logic [8:0] c, input logic [7:0] s,
                           input int bad_lo, input int bad_hi, input int restart_at,
                           input int max_cycles);
    int  k, post, nrsp;
    bit  seen;
    ncmd = 0; ndone = 0; nbusy = 0; done_at = -1;
    k = 0; post = 0; nrsp = 0; seen = 0;
    base_addr = b; count = c; seed = s;
    m_axis_tready = 1'b1; s_axis_tvalid = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    while (k < max_cycles && post < 3) begin
      start = (k == restart_at);
      if (start) begin
        base_addr = b + 8'h40;
        count     = 9'd5;
      end
      if (done) begin
        ndone++;
        if (!seen) done_at = k;
        seen = 1'b1;
      end
      if (busy) nbusy++;
      if (m_axis_tvalid && ncmd < 300) begin
        cmds[ncmd] = m_axis_tdata;
        ncmd++;
      end
      if (s_axis_tready && ncmd > 0) begin
        s_axis_tdata = {24'b0, cmds[ncmd-1][15:8]};
        if (nrsp == bad_lo) s_axis_tdata ^= 32'h0000_0001;
        if (nrsp == bad_hi) s_axis_tdata |= 32'h0010_0000;
        s_axis_tvalid = 1'b1;
        nrsp++;
      end else begin
        s_axis_tvalid = 1'b0;
      end
      if (seen) post++;
      tick();
      k++;
    end
    start = 1'b0;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) tick();
    checks++;
    if (m_axis_tdata !== 32'h0) begin
      errors++; $display("FAIL reset_tdata got=%h exp=00000000", m_axis_tdata);
    end
    checks++;
    if ({m_axis_tvalid, s_axis_tready, busy, done} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=0000", {m_axis_tvalid, s_axis_tready, busy, done});
    end
    checks++;
    if ({err_count, first_err_addr, first_err_valid, timeout} !== 19'b0) begin
      errors++; $display("FAIL reset_status got=%h exp=0", {err_count, first_err_addr, first_err_valid, timeout});
    end
    aresetn = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [31:0] exp_c [4];
    exp_c = '{32'h0000B510, 32'h0000B411, 32'h0000B712, 32'h0000B613};
    run_sweep(8'h10, 9'd4, 8'hA5, -1, -1, -1, 100);
    checks++;
    if (ncmd !== 4) begin errors++; $display("FAIL basic_ncmd got=%0d exp=4", ncmd); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cmds[i] !== exp_c[i]) begin
        errors++; $display("FAIL basic_cmd%0d got=%h exp=%h", i, cmds[i], exp_c[i]);
      end
    end
    checks++;
    if (err_count !== 9'd0) begin errors++; $display("FAIL basic_err got=%0d exp=0", err_count); end
    checks++;
    if ({first_err_valid, timeout} !== 2'b00) begin
      errors++; $display("FAIL basic_flags got=%b exp=00", {first_err_valid, timeout});
    end
    checks++;
    if (ndone !== 1) begin errors++; $display("FAIL basic_done got=%0d exp=1", ndone); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle got=%b exp=0", busy); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_c [3];
    exp_c = '{32'h0000C2FE, 32'h0000C3FF, 32'h00003C00};
    run_sweep(8'hFE, 9'd3, 8'h3C, -1, -1, -1, 100);
    checks++;
    if (ncmd !== 3) begin errors++; $display("FAIL wrap_ncmd got=%0d exp=3", ncmd); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cmds[i] !== exp_c[i]) begin
        errors++; $display("FAIL wrap_cmd%0d got=%h exp=%h", i, cmds[i], exp_c[i]);
      end
    end
    checks++;
    if (err_count !== 9'd0) begin errors++; $display("FAIL wrap_err got=%0d exp=0", err_count); end
  endtask

  task automatic test_error();
    run_sweep(8'h40, 9'd4, 8'h5A, 1, 2, -1, 100);
    checks++;
    if (ncmd !== 4) begin errors++; $display("FAIL error_ncmd got=%0d exp=4", ncmd); end
    checks++;
    if (err_count !== 9'd2) begin errors++; $display("FAIL error_count got=%0d exp=2", err_count); end
    checks++;
    if (first_err_addr !== 8'h41) begin
      errors++; $display("FAIL error_addr got=%h exp=41", first_err_addr);
    end
    checks++;
    if (first_err_valid !== 1'b1) begin
      errors++; $display("FAIL error_valid got=%b exp=1", first_err_valid);
    end
    checks++;
    if (timeout !== 1'b0) begin errors++; $display("FAIL error_timeout got=%b exp=0", timeout); end
  endtask

  task automatic test_backpressure();
    base_addr = 8'h20; count = 9'd1; seed = 8'hFF;
    m_axis_tready = 1'b0; s_axis_tvalid = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h0000DF20) begin
        errors++; $display("FAIL bp_hold%0d got=%b/%h exp=1/0000df20", i, m_axis_tvalid, m_axis_tdata);
      end
      tick();
    end
    m_axis_tready = 1'b1;
    tick();
    checks++;
    if ({m_axis_tvalid, s_axis_tready} !== 2'b01) begin
      errors++; $display("FAIL bp_wait got=%b exp=01", {m_axis_tvalid, s_axis_tready});
    end
    s_axis_tdata = 32'h0000_00DF; s_axis_tvalid = 1'b1;
    tick();
    s_axis_tvalid = 1'b0;
    checks++;
    if (done !== 1'b1 || err_count !== 9'd0) begin
      errors++; $display("FAIL bp_done got=%b/%0d exp=1/0", done, err_count);
    end
    tick();
  endtask

  // respond_at < 0 withholds the read-back entirely
  task automatic timeout_run(input int respond_at, output int n, output int extra);
    base_addr = 8'h80; count = (respond_at < 0) ? 9'd3 : 9'd1; seed = 8'h11;
    m_axis_tready = 1'b1; s_axis_tvalid = 1'b0; s_axis_tdata = 32'h0000_0091; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n = 0; extra = 0;
    while (!done && n < 200) begin
      s_axis_tvalid = (n == respond_at);
      tick();
      n++;
      if (m_axis_tvalid) extra++;
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic test_timeout();
    int n, extra;
    timeout_run(-1, n, extra);
    checks++;
    if (n !== 64) begin errors++; $display("FAIL tmo_latency got=%0d exp=64", n); end
    checks++;
    if (timeout !== 1'b1) begin errors++; $display("FAIL tmo_flag got=%b exp=1", timeout); end
    checks++;
    if (err_count !== 9'd1) begin errors++; $display("FAIL tmo_err got=%0d exp=1", err_count); end
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL tmo_nocmd got=%0d exp=0", extra); end
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL tmo_idle got=%b exp=0", busy); end
  endtask

  task automatic test_timeout_edge();
    int n, extra;
    timeout_run(63, n, extra);
    checks++;
    if (n !== 64) begin errors++; $display("FAIL tmoedge_latency got=%0d exp=64", n); end
    checks++;
    if ({timeout, err_count} !== 10'd0) begin
      errors++; $display("FAIL tmoedge_status got=%b/%0d exp=0/0", timeout, err_count);
    end
    tick();
  endtask

  task automatic test_count_zero();
    run_sweep(8'h33, 9'd0, 8'h00, -1, -1, -1, 20);
    checks++;
    if (done_at !== 0) begin errors++; $display("FAIL cnt0_done_at got=%0d exp=0", done_at); end
    checks++;
    if (ndone !== 1) begin errors++; $display("FAIL cnt0_ndone got=%0d exp=1", ndone); end
    checks++;
    if (nbusy !== 1) begin errors++; $display("FAIL cnt0_busy got=%0d exp=1", nbusy); end
    checks++;
    if (ncmd !== 0) begin errors++; $display("FAIL cnt0_ncmd got=%0d exp=0", ncmd); end
    checks++;
    if ({timeout, err_count} !== 10'd0) begin
      errors++; $display("FAIL cnt0_cleared got=%b/%0d exp=0/0", timeout, err_count);
    end
  endtask

  task automatic test_busy_start();
    run_sweep(8'h50, 9'd2, 8'h0F, -1, -1, 1, 100);
    checks++;
    if (ncmd !== 2) begin errors++; $display("FAIL busystart_ncmd got=%0d exp=2", ncmd); end
    checks++;
    if (cmds[1] !== 32'h00005E51) begin
      errors++; $display("FAIL busystart_cmd1 got=%h exp=00005e51", cmds[1]);
    end
    checks++;
    if (ndone !== 1 || busy !== 1'b0) begin
      errors++; $display("FAIL busystart_end got=%0d/%b exp=1/0", ndone, busy);
    end
  endtask

  task automatic test_count_256();
    run_sweep(8'h05, 9'd256, 8'h77, -1, -1, -1, 2000);
    checks++;
    if (ncmd !== 256) begin errors++; $display("FAIL c256_ncmd got=%0d exp=256", ncmd); end
    checks++;
    if (cmds[0] !== 32'h00007205) begin errors++; $display("FAIL c256_first got=%h exp=00007205", cmds[0]); end
    checks++;
    if (cmds[255] !== 32'h00007304) begin errors++; $display("FAIL c256_last got=%h exp=00007304", cmds[255]); end
    checks++;
    if (err_count !== 9'd0 || ndone !== 1) begin
      errors++; $display("FAIL c256_end got=%0d/%0d exp=0/1", err_count, ndone);
    end
  endtask

  task automatic test_reset_mid();
    int dseen;
    base_addr = 8'h60; count = 9'd3; seed = 8'h00;
    m_axis_tready = 1'b1; s_axis_tvalid = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL rstmid_wait got=%b exp=1", s_axis_tready); end
    #2 aresetn = 1'b0;
    #1;
    checks++;
    if (m_axis_tdata !== 32'h0 || {m_axis_tvalid, s_axis_tready, busy, done} !== 4'b0) begin
      errors++; $display("FAIL rstmid_ctrl got=%h/%b exp=0/0000", m_axis_tdata, {m_axis_tvalid, s_axis_tready, busy, done});
    end
    checks++;
    if ({err_count, first_err_addr, first_err_valid, timeout} !== 19'b0) begin
      errors++; $display("FAIL rstmid_status got=%h exp=0", {err_count, first_err_addr, first_err_valid, timeout});
    end
    dseen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) dseen++;
    end
    aresetn = 1'b1;
    tick();
    if (done) dseen++;
    checks++;
    if (dseen !== 0) begin errors++; $display("FAIL rstmid_nodone got=%0d exp=0", dseen); end
    run_sweep(8'h60, 9'd3, 8'h00, -1, -1, -1, 100);
    checks++;
    if (ncmd !== 3 || cmds[2] !== 32'h00006262) begin
      errors++; $display("FAIL rstmid_restart got=%0d/%h exp=3/00006262", ncmd, cmds[2]);
    end
    checks++;
    if (ndone !== 1 || err_count !== 9'd0) begin
      errors++; $display("FAIL rstmid_end got=%0d/%0d exp=1/0", ndone, err_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_error();
    test_backpressure();
    test_timeout();
    test_count_zero();
    test_timeout_edge();
    test_busy_start();
    test_count_256();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=stalled exp=finished");
    $fatal(1);
  end

endmodule
